// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants, coordinate type and visible-area helper
// for the FlappyBox display pipeline.
package vga_pkg;

  localparam int unsigned HDisplay = 640;
  localparam int unsigned HFront   = 16;
  localparam int unsigned HSync    = 96;
  localparam int unsigned HBack    = 48;
  localparam int unsigned VDisplay = 480;
  localparam int unsigned VFront   = 10;
  localparam int unsigned VSync    = 2;
  localparam int unsigned VBack    = 33;
  localparam int unsigned ClkDiv   = 4;

  localparam int unsigned HTotal = HDisplay + HFront + HSync + HBack;
  localparam int unsigned VTotal = VDisplay + VFront + VSync + VBack;

  localparam int unsigned CoordW = 10;
  typedef logic [CoordW-1:0] coord_t;

  // Exclusive upper bounds of the visible area, shared with the overlay stages.
  localparam coord_t XVisLimit = coord_t'(HDisplay);
  localparam coord_t YVisLimit = coord_t'(VDisplay);

  function automatic logic in_visible(coord_t px, coord_t py, coord_t w, coord_t h);
    return (px < w) && (py < h);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate enable. With VGA_CLKDIV_EN defined a 0..CLK_DIV-1 divider drives p_tick_o;
// otherwise clk_i is already the pixel clock and p_tick_o is constant 1.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = vga_pkg::ClkDiv
) (
  input  logic clk_i,
  input  logic reset_ni,
  output logic p_tick_o
);

`ifdef VGA_CLKDIV_EN
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      div_cnt_q <= '0;
    end else if (div_cnt_q == DivMax) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DivW'(1);
    end
  end

  assign p_tick_o = (div_cnt_q == DivMax);
`else
  // No divider in this build; clock, reset and ratio are intentionally ignored.
  localparam int unsigned UnusedClkDiv = CLK_DIV;
  logic unused_tick_inputs;
  assign unused_tick_inputs = ^{clk_i, reset_ni};

  assign p_tick_o = 1'b1;
`endif

endmodule

// File: rtl/vga_sync.sv
// 640x480@60 Hz VGA timing: h/v counters, registered active-low syncs, visible flag and
// per-frame tick. Pixel-rate divider enabled by VGA_CLKDIV_EN (see pixel_tick_gen).
module vga_sync
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY = HDisplay,
  parameter int unsigned H_FRONT   = HFront,
  parameter int unsigned H_SYNC    = HSync,
  parameter int unsigned H_BACK    = HBack,
  parameter int unsigned V_DISPLAY = VDisplay,
  parameter int unsigned V_FRONT   = VFront,
  parameter int unsigned V_SYNC    = VSync,
  parameter int unsigned V_BACK    = VBack,
  parameter int unsigned CLK_DIV   = ClkDiv
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic              p_tick,
  output logic              frame_tick,
  output logic [CoordW-1:0] x,
  output logic [CoordW-1:0] y
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t HMax       = coord_t'(H_TOTAL - 1);
  localparam coord_t VMax       = coord_t'(V_TOTAL - 1);
  localparam coord_t HVis       = coord_t'(H_DISPLAY);
  localparam coord_t VVis       = coord_t'(V_DISPLAY);
  localparam coord_t HSyncStart = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HSyncEnd   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VSyncStart = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VSyncEnd   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  coord_t h_count_q, h_count_d;
  coord_t v_count_q, v_count_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .p_tick_o (p_tick)
  );

  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (p_tick) begin
      if (h_count_q == HMax) begin
        h_count_d = '0;
        v_count_d = (v_count_q == VMax) ? '0 : v_count_q + coord_t'(1);
      end else begin
        h_count_d = h_count_q + coord_t'(1);
      end
    end
  end

  // Syncs decode the next counts so their edges line up with the x/y update.
  always_comb begin
    hsync_d = !((h_count_d >= HSyncStart) && (h_count_d <= HSyncEnd));
    vsync_d = !((v_count_d >= VSyncStart) && (v_count_d <= VSyncEnd));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_count_q <= '0;
      v_count_q <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign x          = h_count_q;
  assign y          = v_count_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = in_visible(h_count_q, v_count_q, HVis, VVis);
  assign frame_tick = p_tick && (h_count_q == HMax) && (v_count_q == VMax);

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: a standard-timing instance for reset/line checks and a
// short-frame instance (6 lines) so frame, vsync and mid-frame reset fit a short run.
module tb_vga_sync;

`ifdef VGA_CLKDIV_EN
  localparam int Div = 4;
`else
  localparam int Div = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       hs, vs, von, pt, ft;
  logic [9:0] x, y;
  logic       s_hs, s_vs, s_von, s_pt, s_ft;
  logic [9:0] s_x, s_y;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_sync dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hsync      (hs),
    .vsync      (vs),
    .video_on   (von),
    .p_tick     (pt),
    .frame_tick (ft),
    .x          (x),
    .y          (y)
  );

  // Short frame: 2 visible lines, vsync low on lines 3..4, 6 lines total.
  vga_sync #(
    .V_DISPLAY (2),
    .V_FRONT   (1),
    .V_SYNC    (2),
    .V_BACK    (1)
  ) dut_s (
    .clk        (clk),
    .reset_n    (reset_n),
    .hsync      (s_hs),
    .vsync      (s_vs),
    .video_on   (s_von),
    .p_tick     (s_pt),
    .frame_tick (s_ft),
    .x          (s_x),
    .y          (s_y)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt, cyc, ticks, hlow, hfx, hrx, lines, vlow, vfy, vfx, vry, ftn, ftx, fty, npt, viol;
    logic va, vb, vc;
    logic [9:0] px;
    logic ppt;
    bit seen;

    // Reset held for 10 cycles
    reset_n = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_hsync", hs, 1);
    chk("rst_vsync", vs, 1);
    chk("rst_video_on", von, 1);
    chk("rst_p_tick", pt, (Div == 1));
    chk("rst_frame_tick", ft, 0);
    chk("rst_s_vsync", s_vs, 1);

    // First tick: x becomes 1 on edge Div after release
    reset_n = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (x != 10'd1 && cnt < 20);
    chk("first_tick_edges", cnt, Div);
    chk("first_tick_y", y, 0);

    // Line timing, starting at the first cycle of the next x == 0
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (x != 10'd0 && cnt < 2000 * Div);
    chk("wait_line_start", x, 0);
    ticks = 0; hlow = 0; hfx = -1; hrx = -1; cyc = 0; seen = 0; va = 1'bx; vb = 1'bx;
    while (cyc < 2000 * Div) begin
      if (pt) ticks++;
      if (pt && x == 10'd639) va = von;
      if (pt && x == 10'd640) vb = von;
      if (!hs) begin
        if (pt) hlow++;
        if (hfx < 0) hfx = x;
      end else if (hfx >= 0 && hrx < 0) begin
        hrx = x;
      end
      @(negedge clk);
      cyc++;
      if (x != 10'd0) seen = 1;
      else if (seen) break;
    end
    chk("line_ticks", ticks, 800);
    chk("line_cycles", cyc, 800 * Div);
    chk("hsync_low_ticks", hlow, 96);
    chk("hsync_fall_x", hfx, 656);
    chk("hsync_rise_x", hrx, 752);
    chk("von_639_y1", va, 1);
    chk("von_640_y1", vb, 0);

    // Frame timing on the short-frame instance
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(s_x == 10'd0 && s_y == 10'd0) && cnt < 6000 * Div);
    chk("wait_frame_start", {s_x, s_y}, 0);
    ticks = 0; lines = 0; vlow = 0; vfy = -1; vfx = -1; vry = -1;
    ftn = 0; ftx = -1; fty = -1; cyc = 0; seen = 0; va = 1'bx; vb = 1'bx; vc = 1'bx;
    while (cyc < 10000 * Div) begin
      if (s_pt) begin
        ticks++;
        if (s_x == 10'd799) lines++;
        if (!s_vs) vlow++;
        if (s_x == 10'd639 && s_y == 10'd1) va = s_von;
        if (s_x == 10'd0 && s_y == 10'd2) vb = s_von;
        if (s_x == 10'd799 && s_y == 10'd5) vc = s_von;
      end
      if (s_ft) begin
        ftn++;
        ftx = s_x;
        fty = s_y;
      end
      if (!s_vs) begin
        if (vfy < 0) begin
          vfy = s_y;
          vfx = s_x;
        end
      end else if (vfy >= 0 && vry < 0) begin
        vry = s_y;
      end
      @(negedge clk);
      cyc++;
      if (s_x != 10'd0 || s_y != 10'd0) seen = 1;
      else if (seen) break;
    end
    chk("frame_ticks", ticks, 4800);
    chk("frame_cycles", cyc, 4800 * Div);
    chk("frame_lines", lines, 6);
    chk("vsync_low_ticks", vlow, 1600);
    chk("vsync_fall_y", vfy, 3);
    chk("vsync_fall_x", vfx, 0);
    chk("vsync_rise_y", vry, 5);
    chk("frame_tick_count", ftn, 1);
    chk("frame_tick_x", ftx, 799);
    chk("frame_tick_y", fty, 5);
    chk("von_last_visible", va, 1);
    chk("von_first_invisible_line", vb, 0);
    chk("von_last_pixel", vc, 0);

    // Reset mid-frame while vsync is low (second sync line)
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(s_x == 10'd700 && s_y == 10'd4) && cnt < 6000 * Div);
    chk("wait_mid_frame", {s_x, s_y}, {10'd700, 10'd4});
    chk("mid_vsync_low", s_vs, 0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_x", s_x, 0);
    chk("mid_rst_y", s_y, 0);
    chk("mid_rst_hsync", s_hs, 1);
    chk("mid_rst_vsync", s_vs, 1);
    chk("mid_rst_dut_xy", {x, y}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (s_vs && cnt < 6000 * Div);
    chk("restart_vsync_fall_y", s_y, 3);
    chk("restart_vsync_fall_x", s_x, 0);

    // Tick cadence and x stepping over 400 cycles
    @(negedge clk);
    px = x; ppt = pt; npt = 0; viol = 0;
    repeat (400) begin
      @(negedge clk);
      if (ppt) npt++;
      if (x !== (ppt ? ((px == 10'd799) ? 10'd0 : px + 10'd1) : px)) viol++;
      px = x;
      ppt = pt;
    end
    chk("p_tick_count_400", npt, 400 / Div);
    chk("x_step_violations", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
